// File: rtl/contador_pkg.sv
// Shared constants for the run controller: FSM state encoding and
// the default prescaler period.
package contador_pkg;

    localparam int TICK_DIV_DEF = 50_000_000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/contador_ctrl_tick_gen.sv
// Count-tick prescaler: one-cycle tick every TICK_DIV enabled cycles,
// holds while disabled, synchronous clear wins over enable.
module tick_gen
    import contador_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF,
    parameter int DIV_W    = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [DIV_W-1:0] LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/contador_ctrl.sv
// Run controller for the up-counter: button edge detect, IDLE/RUN/
// PAUSE/DONE sequencing, terminal-count compare and status flags.
module contador_ctrl
    import contador_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF,
    parameter int DIV_W    = 26,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic [CNT_W-1:0] target,
    output logic [CNT_W-1:0] count,
    output logic             tick,
    output logic             running,
    output logic             paused,
    output logic             done,
    output logic             done_pulse
);

    state_t           state, state_n;
    logic [CNT_W-1:0] count_n, count_inc;
    logic [CNT_W-1:0] tgt, tgt_n;
    logic             start_q, stop_q, clear_q;
    logic             armed;
    logic             do_start, do_stop, do_clr;
    logic             start_req, stop_req, clear_req;

    // armed masks the first cycle after reset so held levels make no edge
    assign start_req = armed & start & ~start_q;
    assign stop_req  = armed & stop  & ~stop_q;
    assign clear_req = armed & clear & ~clear_q;

    assign do_clr   = clear_req;
    assign do_stop  = stop_req & ~clear_req;
    assign do_start = start_req & ~stop_req & ~clear_req;

    assign count_inc = count + CNT_W'(1);
    assign running   = (state == ST_RUN);
    assign paused    = (state == ST_PAUSE);

    tick_gen #(
        .TICK_DIV (TICK_DIV),
        .DIV_W    (DIV_W)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (state == ST_RUN),
        .clr  ((state == ST_IDLE) || (state == ST_DONE)),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed   <= 1'b0;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            armed   <= 1'b1;
            start_q <= start;
            stop_q  <= stop;
            clear_q <= clear;
        end
    end

    always_comb begin
        state_n = state;
        count_n = count;
        tgt_n   = tgt;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (do_clr) begin
                    state_n = ST_IDLE;
                    count_n = '0;
                end else if (do_start) begin
                    tgt_n   = target;
                    count_n = '0;
                    state_n = (target == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (do_clr) begin
                    state_n = ST_IDLE;
                    count_n = '0;
                end else begin
                    if (tick) count_n = count_inc;
                    // completion beats a same-cycle pause
                    if (tick && (count_inc == tgt)) state_n = ST_DONE;
                    else if (do_stop)               state_n = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (do_clr) begin
                    state_n = ST_IDLE;
                    count_n = '0;
                end else if (do_start) begin
                    state_n = ST_RUN;
                end
            end
            default: begin
                state_n = ST_IDLE;
                count_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            count      <= '0;
            tgt        <= '0;
            done       <= 1'b0;
            done_pulse <= 1'b0;
        end else begin
            state      <= state_n;
            count      <= count_n;
            tgt        <= tgt_n;
            done       <= (state_n == ST_DONE);
            done_pulse <= (state_n == ST_DONE) && ((state != ST_DONE) || do_start);
        end
    end

endmodule

// File: tb/tb_contador_ctrl.sv
// Self-checking bench for contador_ctrl: directed scenarios plus random
// button traffic against a cycle-level behavioural model.
module tb_contador_ctrl;

    localparam int DIV = 4;
    localparam int CW  = 4;
    localparam int MOD = 1 << CW;

    localparam int M_IDLE  = 10;
    localparam int M_RUN   = 11;
    localparam int M_PAUSE = 12;
    localparam int M_DONE  = 13;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, stop, clear;
    logic [CW-1:0] target;
    logic [CW-1:0] count;
    logic          tick, running, paused, done, done_pulse;

    int n_chk  = 0;
    int n_pass = 0;

    int m_mode, m_cnt, m_tgt, m_phase;
    bit m_pulse, m_armed, p_s, p_p, p_c;

    contador_ctrl #(
        .TICK_DIV (DIV),
        .DIV_W    (3),
        .CNT_W    (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .clear      (clear),
        .target     (target),
        .count      (count),
        .tick       (tick),
        .running    (running),
        .paused     (paused),
        .done       (done),
        .done_pulse (done_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    task automatic m_reset();
        m_mode  = M_IDLE;
        m_cnt   = 0;
        m_tgt   = 0;
        m_phase = 0;
        m_pulse = 0;
        m_armed = 0;
        p_s     = 0;
        p_p     = 0;
        p_c     = 0;
    endtask

    task automatic m_fresh(input int t);
        m_tgt   = t;
        m_cnt   = 0;
        m_phase = 0;
        if (t == 0) begin
            m_mode  = M_DONE;
            m_pulse = 1;
        end else begin
            m_mode = M_RUN;
        end
    endtask

    // advance the model across one clock edge with the given inputs
    task automatic m_step(input bit s, input bit p, input bit c, input int t);
        bit rs, rp, rc, ws, wp, wc, tk;
        rs = m_armed && s && !p_s;
        rp = m_armed && p && !p_p;
        rc = m_armed && c && !p_c;
        wc = rc;
        wp = rp && !rc;
        ws = rs && !rp && !rc;
        tk = (m_mode == M_RUN) && (m_phase == DIV - 1);
        m_pulse = 0;
        case (m_mode)
            M_IDLE: if (ws) m_fresh(t);
            M_RUN: begin
                m_phase = (m_phase + 1) % DIV;
                if (wc) begin
                    m_mode = M_IDLE;
                    m_cnt  = 0;
                end else begin
                    if (tk) m_cnt = (m_cnt + 1) % MOD;
                    if (tk && m_cnt == m_tgt) begin
                        m_mode  = M_DONE;
                        m_pulse = 1;
                    end else if (wp) begin
                        m_mode = M_PAUSE;
                    end
                end
            end
            M_PAUSE: begin
                if (wc) begin
                    m_mode = M_IDLE;
                    m_cnt  = 0;
                end else if (ws) begin
                    m_mode = M_RUN;
                end
            end
            default: begin
                if (wc) begin
                    m_mode = M_IDLE;
                    m_cnt  = 0;
                end else if (ws) begin
                    m_fresh(t);
                end
            end
        endcase
        m_armed = 1;
        p_s = s;
        p_p = p;
        p_c = c;
    endtask

    task automatic compare_all();
        check("count", count, m_cnt);
        check("tick", tick, int'((m_mode == M_RUN) && (m_phase == DIV - 1)));
        check("running", running, int'(m_mode == M_RUN));
        check("paused", paused, int'(m_mode == M_PAUSE));
        check("done", done, int'(m_mode == M_DONE));
        check("done_pulse", done_pulse, int'(m_pulse));
    endtask

    // compare current outputs, then drive one cycle of inputs
    task automatic cyc(input bit s, input bit p, input bit c, input int t);
        @(negedge clk);
        compare_all();
        start  = s;
        stop   = p;
        clear  = c;
        target = CW'(t);
        m_step(s, p, c, t);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        stop   = 1'b0;
        clear  = 1'b0;
        target = '0;
        m_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // normal run to 5
        cyc(0, 0, 0, 5);
        cyc(1, 0, 0, 5);
        repeat (24) cyc(0, 0, 0, 5);
        check("end_count5", count, 5);
        check("end_done", done, 1);

        // pause two cycles after the 2nd tick, then resume
        cyc(0, 0, 1, 5);
        cyc(0, 0, 0, 5);
        cyc(1, 0, 0, 5);
        repeat (9) cyc(0, 0, 0, 5);
        cyc(0, 1, 0, 5);
        cyc(0, 0, 0, 5);
        cyc(0, 0, 0, 5);
        check("pause_flag", paused, 1);
        check("pause_count", count, 2);
        cyc(1, 0, 0, 5);
        cyc(0, 0, 0, 5);
        check("resume_wait", tick, 0);
        cyc(0, 0, 0, 5);
        check("resume_tick", tick, 1);

        // clear+start together, then stop+start together
        cyc(1, 0, 1, 5);
        cyc(0, 0, 0, 9);
        check("clr_pri_run", running, 0);
        check("clr_pri_cnt", count, 0);
        cyc(1, 0, 0, 9);
        repeat (3) cyc(0, 0, 0, 9);
        cyc(1, 1, 0, 9);
        cyc(0, 0, 0, 9);
        check("stop_pri", paused, 1);

        // target 0 goes straight to DONE
        cyc(0, 0, 1, 9);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        check("t0_done", done, 1);
        check("t0_pulse", done_pulse, 1);
        check("t0_count", count, 0);
        cyc(0, 0, 0, 0);
        check("t0_pulse_once", done_pulse, 0);

        // target 15, no wrap
        cyc(0, 0, 1, 15);
        cyc(0, 0, 0, 15);
        cyc(1, 0, 0, 15);
        repeat (64) cyc(0, 0, 0, 15);
        check("t15_count", count, 15);
        check("t15_done", done, 1);

        // held start, target changed mid-run
        cyc(0, 0, 1, 5);
        cyc(0, 0, 0, 5);
        for (int i = 0; i < 20; i++) cyc(1, 0, 0, (i < 8) ? 5 : 2);
        repeat (4) cyc(0, 0, 0, 2);
        check("held_count", count, 5);
        check("held_done", done, 1);

        // async reset mid-run at count 3, start held through it
        cyc(0, 0, 1, 9);
        cyc(0, 0, 0, 9);
        cyc(1, 0, 0, 9);
        repeat (13) cyc(0, 0, 0, 9);
        cyc(1, 0, 0, 9);
        check("pre_rst_count", count, 3);
        #2 rst = 1'b1;
        #1;
        check("rst_count", count, 0);
        check("rst_running", running, 0);
        check("rst_tick", tick, 0);
        check("rst_done", done, 0);
        check("rst_pulse", done_pulse, 0);
        m_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (8) cyc(1, 0, 0, 9);
        check("held_rst_idle", running, 0);

        // random button traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom % 6) == 0, ($urandom % 16) == 0,
                ($urandom % 40) == 0, int'($urandom % MOD));
        end
        @(negedge clk);
        compare_all();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/contador_ctrl.md
Name: contador_ctrl

Overview:
Run controller for the team's 4-bit up-counter datapath. Generates its own single-cycle tick enable from clk instead of a derived divided clock, and sequences counting through IDLE/RUN/PAUSE/DONE using start/stop/clear button inputs. Stops at a programmable target and flags completion. Sits between the board buttons/switches and the display logic.

Parameters:
TICK_DIV, 50_000_000, clk cycles per count tick (1 Hz at 50 MHz); legal values ≥ 2
DIV_W, 26, width of the tick prescaler counter; must satisfy 2^DIV_W ≥ TICK_DIV
CNT_W, 4, width of count and target

Ports:
clk  input  1  system clock; all logic in this single domain
rst  input  1  asynchronous, active-high reset
start  input  1  level, already synchronized; rising edge = start/resume request
stop  input  1  level, already synchronized; rising edge = pause request
clear  input  1  level, already synchronized; rising edge = clear request
target  input  CNT_W  terminal count; sampled on an accepted start from IDLE
count  output  CNT_W  current count value
tick  output  1  one-cycle pulse every TICK_DIV cycles while in RUN
running  output  1  high in RUN
paused  output  1  high in PAUSE
done  output  1  high in DONE (level)
done_pulse  output  1  one-cycle pulse on entry to DONE

Behaviour:
- Reset (async, active-high): state=IDLE; count=0; prescaler=0; latched target=0; edge-detect registers=0; all outputs 0.
- Edge detect: registered previous value per input. A request is a rising edge, i.e. at most one request per press. Level held through reset produces no request after reset release.
- Request priority within a cycle: clear > stop > start.
- Prescaler: advances only in RUN. At TICK_DIV-1 it wraps to 0 and tick=1 for that cycle. It holds its value in PAUSE and is zeroed in IDLE and DONE.
- FSM transitions:
  - IDLE, on start: latch target, count=0, go to RUN. If target==0, go directly to DONE with done_pulse on the next cycle.
  - RUN, on tick: count<=count+1. If count+1==latched target, go to DONE and assert done_pulse in the following cycle. Otherwise stay in RUN.
  - RUN, on stop: go to PAUSE. A tick in the same cycle is still applied.
  - RUN, on clear: go to IDLE with count=0. This overrides a simultaneous tick.
  - PAUSE, on start: resume RUN with the prescaler value and count preserved.
  - PAUSE, on clear: go to IDLE with count=0.
  - PAUSE, on stop: ignored.
  - DONE: count holds the target value. On clear, go to IDLE with count=0. On start, behave as a restart from IDLE: re-latch target, count=0, go to RUN.
- Width/wrap: count is unsigned modulo 2^CNT_W. The terminal compare always matches before wrap because target < 2^CNT_W.
- Latency:
  - Request edge to state change: 1 cycle after the input register.
  - tick to count update: same edge.
  - done and done_pulse are registered outputs.
- Target changes while in RUN/PAUSE are ignored until the next accepted start.
- Reset mid-run aborts immediately. No partial state survives.

Decomposition:
- Shared package (contador_pkg): state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_PAUSE=2'd2, ST_DONE=2'd3, and the default TICK_DIV constant.
- Sub-module tick_gen (clk, rst, en, clr → tick): the prescaler. Parameterized by TICK_DIV/DIV_W. Counts while en and synchronously clears on clr.
- FSM, edge detect and counter live in contador_ctrl.

Test Plan (TICK_DIV=4 unless stated):
- Reset values: assert rst mid-RUN with count=3 → all outputs 0 and state IDLE asynchronously. No tick appears until a new start.
- Normal count: target=5, start pulse → tick every 4 cycles. count steps 1..5; after the 5th tick done=1 and done_pulse=1 for exactly one cycle. count stays 5 and no further ticks occur.
- Pause/resume: stop 2 cycles after the 2nd tick → count=2 and paused=1 with prescaler frozen. After start, the 3rd tick arrives exactly 2 cycles later (remaining prescaler period).
- Priority: clear and start rising in the same cycle while in RUN → state IDLE, count=0. Stop and start together in RUN → PAUSE.
- Boundary target: target=0 with start → DONE next cycle, done_pulse once, count=0. target=15 → reaches 15 with no wrap to 0.
- Held buttons: start held high for 20 cycles → exactly one start accepted. Target changed to 2 mid-run while target was 5 → run still ends at 5.
